// File: rtl/set.sv
// ----------------------------------------------------------------------------
// set -- counts the grid points of an 8x8 universe that fall in a set built
//        from up to three circles A, B, C.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         one-cycle start strobe, taken only while busy=0
//   central    {xA,yA,xB,yB,xC,yC}, 4 bits each
//   radius     {rA,rB,rC}, 4 bits each
//   mode       00: A   01: A|B   10: A^B   11: exactly two of A,B,C
//   busy       high from the accepting edge through the OUT cycle
//   valid      one-cycle pulse with the result
//   candidate  point count (0..64), held until the next job's OUT
//
// Timing: the en edge enters CALC. Each of the following 64 cycles scores one
// point, x-major from (1,1) to (8,8). The 64th edge after the en edge loads
// candidate and raises valid (latency 64 edges). The block is back in IDLE
// one cycle later and can take en in that IDLE cycle.
// ----------------------------------------------------------------------------
module set (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [23:0] central,
    input  logic [11:0] radius,
    input  logic [1:0]  mode,
    output logic        busy,
    output logic        valid,
    output logic [7:0]  candidate
);

    localparam int NUM_CIRC = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]          state;
    logic [23:0]         cen_q;
    logic [11:0]         rad_q;
    logic [1:0]          mode_q;
    logic [5:0]          idx;
    logic [7:0]          cnt;
    logic [3:0]          px, py;
    logic [NUM_CIRC-1:0] hit;
    logic                match;

    // idx[5:3] walks x, idx[2:0] walks y, so x is the outer loop
    assign px = {1'b0, idx[5:3]} + 4'd1;
    assign py = {1'b0, idx[2:0]} + 4'd1;

    // hit[0]=A, hit[1]=B, hit[2]=C
    genvar k;
    generate
        for (k = 0; k < NUM_CIRC; k++) begin : g_circ
            set_circ_chk u_chk (
                .px  (px),
                .py  (py),
                .cx  (cen_q[23-8*k -: 4]),
                .cy  (cen_q[19-8*k -: 4]),
                .r   (rad_q[11-4*k -: 4]),
                .hit (hit[k])
            );
        end
    endgenerate

    always_comb begin
        match = 1'b0;
        case (mode_q)
            2'b00:   match = hit[0];
            2'b01:   match = hit[0] | hit[1];
            2'b10:   match = hit[0] ^ hit[1];
            default: match = (hit[0] & hit[1] & ~hit[2]) |
                             (hit[0] & ~hit[1] & hit[2]) |
                             (~hit[0] & hit[1] & hit[2]);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cen_q     <= '0;
            rad_q     <= '0;
            mode_q    <= '0;
            idx       <= '0;
            cnt       <= '0;
            candidate <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) begin
                        cen_q  <= central;
                        rad_q  <= radius;
                        mode_q <= mode;
                        idx    <= '0;
                        cnt    <= '0;
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    cnt <= cnt + {7'd0, match};
                    idx <= idx + 6'd1;
                    if (idx == 6'd63) begin
                        // include the last point's match directly
                        candidate <= cnt + {7'd0, match};
                        state     <= S_OUT;
                    end
                end
                S_OUT:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy  = (state != S_IDLE);
    assign valid = (state == S_OUT);

endmodule

// One circle membership test: (px-cx)^2 + (py-cy)^2 <= r^2.
// Each square is at most 225, so a 10-bit sum cannot overflow.
module set_circ_chk (
    input  logic [3:0] px,
    input  logic [3:0] py,
    input  logic [3:0] cx,
    input  logic [3:0] cy,
    input  logic [3:0] r,
    output logic       hit
);

    logic [3:0] dx, dy;
    logic [9:0] dx2, dy2, rr;

    always_comb begin
        dx  = (px >= cx) ? (px - cx) : (cx - px);
        dy  = (py >= cy) ? (py - cy) : (cy - py);
        dx2 = {6'd0, dx} * {6'd0, dx};
        dy2 = {6'd0, dy} * {6'd0, dy};
        rr  = {6'd0, r}  * {6'd0, r};
        hit = (dx2 + dy2) <= rr;
    end

endmodule

// File: tb/tb_set.sv
module tb_set;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [23:0] central = '0;
    logic [11:0] radius  = '0;
    logic [1:0]  mode    = '0;
    logic        busy, valid;
    logic [7:0]  candidate;

    set dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .central   (central),
        .radius    (radius),
        .mode      (mode),
        .busy      (busy),
        .valid     (valid),
        .candidate (candidate)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   last_cand = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: brute-force count over the 8x8 grid.
    function automatic int model(input logic [23:0] c, input logic [11:0] r,
                                 input logic [1:0] m);
        int n = 0;
        for (int x = 1; x <= 8; x++) begin
            for (int y = 1; y <= 8; y++) begin
                int in_k[3];
                int s;
                for (int k = 0; k < 3; k++) begin
                    int cx = int'(c[23-8*k -: 4]);
                    int cy = int'(c[19-8*k -: 4]);
                    int rk = int'(r[11-4*k -: 4]);
                    in_k[k] = ((x-cx)*(x-cx) + (y-cy)*(y-cy) <= rk*rk) ? 1 : 0;
                end
                case (m)
                    2'b00:   s = in_k[0];
                    2'b01:   s = (in_k[0] | in_k[1]);
                    2'b10:   s = (in_k[0] != in_k[1]) ? 1 : 0;
                    default: s = (in_k[0] + in_k[1] + in_k[2] == 2) ? 1 : 0;
                endcase
                n += s;
            end
        end
        return n;
    endfunction

    // Monitor: pops on every valid, checks value and latency; between pulses
    // the held candidate must not move.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("candidate", int'(candidate), e.val);
                    chk("latency", cyc - e.cyc, 64);
                    chk("busy_at_valid", int'(busy), 1);
                end
                last_cand = int'(candidate);
            end else begin
                chk("cand_stable", int'(candidate), last_cand);
            end
        end
    end

    // Called at a negedge with busy=0: en lands in this IDLE cycle.
    task automatic start_job(input logic [23:0] c, input logic [11:0] r,
                             input logic [1:0] m);
        exp_t e;
        central = c;
        radius  = r;
        mode    = m;
        en      = 1'b1;
        e.val   = model(c, r, m);
        e.cyc   = cyc + 1;
        sbq.push_back(e);
        @(negedge clk);
        en      = 1'b0;
        central = 24'($urandom);
        radius  = 12'($urandom);
        mode    = 2'($urandom);
    endtask

    // Wait for IDLE; optionally throw ignored en pulses and input noise.
    task automatic wait_idle(input bit noise);
        int t = 0;
        while (busy && t < 300) begin
            if (noise) begin
                en      = ($urandom_range(0, 5) == 0);
                central = 24'($urandom);
                radius  = 12'($urandom);
                mode    = 2'($urandom);
            end
            @(negedge clk);
            t++;
        end
        en = 1'b0;
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic job(input logic [23:0] c, input logic [11:0] r,
                       input logic [1:0] m);
        start_job(c, r, m);
        wait_idle(1'b0);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_cand",  int'(candidate), 0);
        #2 rst = 1'b0;
        @(negedge clk);

        // directed scenarios
        job(24'h440000, 12'h200, 2'b00);   // 13
        job(24'h440000, 12'h000, 2'b00);   // 1
        job(24'h110000, 12'h100, 2'b00);   // 3, clipped
        job(24'h440000, 12'h800, 2'b00);   // 64
        job(24'h445400, 12'h110, 2'b01);   // 8
        job(24'h445400, 12'h110, 2'b10);   // 6
        job(24'h445488, 12'h110, 2'b11);   // 2
        job(24'h44FFFF, 12'h2FF, 2'b00);   // B/C fields must not matter
        job(24'hFFFFFF, 12'hFFF, 2'b11);   // max operands, no overflow
        job(24'h000000, 12'h000, 2'b01);   // centres off grid

        // back-to-back random jobs with ignored en pulses during busy
        for (int i = 0; i < 64; i++) begin
            start_job(24'($urandom), 12'($urandom), 2'($urandom));
            wait_idle(1'b1);
        end

        // reset during CALC
        start_job(24'h440000, 12'h300, 2'b00);
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy",  int'(busy), 0);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_cand",  int'(candidate), 0);
        sbq.delete();
        last_cand = 0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        job(24'h445400, 12'h110, 2'b10);
        job(24'($urandom), 12'($urandom), 2'b11);

        repeat (3) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
